// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused with a borrow flop; start/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             cell_x, cell_y, cell_r;
    logic             cell_d, cell_rn;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell on the current LSBs and the stored borrow.
    always_comb begin
        cell_x    = a_sh_q[0];
        cell_y    = b_sh_q[0];
        cell_r    = borrow_q;
        cell_d    = cell_x ^ cell_y ^ cell_r;
        cell_rn   = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_r);
        res_ext   = {cell_d, res_q};
        res_shift = res_ext[WIDTH:1];
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Inputs are only looked at on an accepted start.
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    res_d    = '0;
                    count_d  = '0;
                    state_d  = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_shift;
                borrow_d = cell_rn;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LastCnt) begin
                    diff_d  = res_shift;
                    bout_d  = cell_rn;
                    ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == StBusy);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first.
- A single registered half/full-subtractor cell is reused with a borrow flip-flop.
- Successor to the combinational half-subtractor cell, trading latency for area.
- Intended for arithmetic datapaths where a one-shot start/done handshake is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  two's-complement overflow flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and counter cleared.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at an edge: capture a, b into shift regs and bin into the borrow flop; count=0; go to BUSY; busy=1 from that edge.
  - Otherwise remain in IDLE.
- BUSY, each edge:
  - Bit cell takes x=a_sh[0], y=b_sh[0], r=borrow.
  - d = x^y^r.
  - r' = (~x&y) | (~(x^y)&r).
  - d shifts into the MSB of the result shift reg; a_sh and b_sh shift right; count increments.
  - start is ignored in BUSY; captured operands are unaffected by input changes.
- Completion, at the edge where count reaches WIDTH:
  - diff <= result shift reg including the final bit.
  - bout <= r'.
  - ovf <= (a_msb != b_msb) && (diff_msb != a_msb), using the captured MSBs.
  - done=1, busy=0, state=DONE.
- Latency: start accepted at edge 0; done high in the cycle following edge WIDTH, i.e. exactly WIDTH cycles after acceptance.
- DONE, lasts one cycle:
  - done returns to 0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back), going to BUSY; otherwise go to IDLE.
- diff, bout and ovf hold their values until the next completion; they do not change during BUSY.
- WIDTH=1: single-cycle pass through the cell; bin=0 reproduces the half-subtractor truth table.
- ovf is defined with bin included in the subtraction.
- No X propagation from the inputs is allowed while IDLE.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles; done 8 cycles after acceptance; diff=0x02, bout=0, ovf=0.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
- WIDTH=8, a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
- Second start asserted mid-BUSY with different a/b -> ignored; first result unchanged. Start held high in the DONE cycle -> new operation accepted with no idle gap; the next done follows 8 cycles later.
- rst_n pulsed low at cycle 4 of an operation -> all outputs 0 immediately, no done pulse; a fresh start afterwards gives the correct result.
- WIDTH=1, exhaustive a,b with bin=0 -> (0,0):diff0 bout0; (0,1):1,1; (1,0):1,0; (1,1):0,0. Each done arrives 1 cycle after start.
